// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and writeback sequencer for the
// 8-bit pipelined core.
//
// Takes one retiring instruction per cycle from MEM and selects its result
// (ALU, load, link = pc+1, immediate). A load whose data has not arrived parks
// the stage in LOAD_WAIT until mem_rvalid. It drives the register-file write
// port and exports forwarding/hazard info and a retired-instruction counter.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   handshake with the MEM stage (in_ready combinational)
//   in_reg_write, in_rd, in_wb_sel, in_alu_result, in_pc, in_imm
//                       retiring instruction fields
//   mem_rvalid/mem_rdata late load data
//   flush               kill the incoming or pending instruction
//   write_enable/_address/_data   register-file write port (registered)
//   fwd_valid/fwd_data  mirror of write_enable/write_data
//   fwd_pending/fwd_rd  load outstanding for fwd_rd; decode stalls on match
//   retired_count       completed instructions, wraps
module writeback_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              fwd_valid,
    output logic              fwd_pending,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired_count
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    localparam logic [1:0]        SEL_ALU  = 2'b00;
    localparam logic [1:0]        SEL_LOAD = 2'b01;
    localparam logic [1:0]        SEL_LINK = 2'b10;
    localparam logic [DATA_W-1:0] D_ONE    = 1;
    localparam logic [CNT_W-1:0]  C_ONE    = 1;
    localparam logic [ADDR_W-1:0] R_ZERO   = '0;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                pend_q, pend_d;
    logic [ADDR_W-1:0]   fwd_rd_q, fwd_rd_d;
    logic [ADDR_W-1:0]   prd_q, prd_d;    // rd of the parked load
    logic                prw_q, prw_d;    // reg_write of the parked load
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   sel_data;
    logic                accept;

    // Result mux; a load only reaches this path when its data is here now.
    always_comb begin
        case (in_wb_sel)
            SEL_ALU:  sel_data = in_alu_result;
            SEL_LOAD: sel_data = mem_rdata;
            SEL_LINK: sel_data = in_pc + D_ONE;   // truncates, 0xFF -> 0x00
            default:  sel_data = in_imm;
        endcase
    end

    assign accept = in_valid && in_ready && !flush;

    // State register (and all registered outputs).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            pend_q   <= 1'b0;
            fwd_rd_q <= '0;
            prd_q    <= '0;
            prw_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            pend_q   <= pend_d;
            fwd_rd_q <= fwd_rd_d;
            prd_q    <= prd_d;
            prw_q    <= prw_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic. Address/data/fwd_rd hold unless an instruction completes.
    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        pend_d   = pend_q;
        fwd_rd_d = fwd_rd_q;
        prd_d    = prd_q;
        prw_d    = prw_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_wb_sel != SEL_LOAD || mem_rvalid) begin
                        we_d     = in_reg_write && (in_rd != R_ZERO);
                        waddr_d  = in_rd;
                        wdata_d  = sel_data;
                        fwd_rd_d = in_rd;
                        cnt_d    = cnt_q + C_ONE;
                    end else begin
                        state_d = LOAD_WAIT;
                        prd_d   = in_rd;
                        prw_d   = in_reg_write;
                        // Only a real destination can create a hazard.
                        if (in_reg_write && in_rd != R_ZERO) begin
                            pend_d   = 1'b1;
                            fwd_rd_d = in_rd;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                // flush wins over a simultaneous mem_rvalid.
                if (flush) begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end else if (mem_rvalid) begin
                    state_d  = IDLE;
                    pend_d   = 1'b0;
                    we_d     = prw_q && (prd_q != R_ZERO);
                    waddr_d  = prd_q;
                    wdata_d  = mem_rdata;
                    fwd_rd_d = prd_q;
                    cnt_d    = cnt_q + C_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
    end

    assign write_enable  = we_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign fwd_valid     = we_q;
    assign fwd_data      = wdata_q;
    assign fwd_pending   = pend_q;
    assign fwd_rd        = fwd_rd_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_reg_write;
    logic [2:0] in_rd;
    logic [1:0] in_wb_sel;
    logic [7:0] in_alu_result, in_pc, in_imm, mem_rdata;
    logic       mem_rvalid, flush;
    logic       write_enable, fwd_valid, fwd_pending;
    logic [2:0] write_address, fwd_rd;
    logic [7:0] write_data, fwd_data;
    logic [15:0] retired_count;

    writeback_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd(in_rd), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc(in_pc), .in_imm(in_imm),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .flush(flush),
        .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .fwd_valid(fwd_valid),
        .fwd_pending(fwd_pending), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;
    wr_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h expected no write", write_address, write_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr",  {29'd0, write_address}, {29'd0, e.a});
                chk("wr_data",  {24'd0, write_data},    {24'd0, e.d});
                chk("fwd_valid", {31'd0, fwd_valid},    32'd1);
                chk("fwd_data", {24'd0, fwd_data},      {24'd0, e.d});
                chk("fwd_rd",   {29'd0, fwd_rd},        {29'd0, e.a});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_reg_write = 0; in_rd = 0; in_wb_sel = 0;
        in_alu_result = 0; in_pc = 0; in_imm = 0;
        mem_rvalid = 0; mem_rdata = 0; flush = 0;
    endtask

    // Present one instruction for a cycle; expect a write when exp_wr is set.
    task automatic op(input logic rw, input logic [2:0] rd, input logic [1:0] sel,
                      input logic [7:0] alu, input logic [7:0] pc, input logic [7:0] imm,
                      input logic rv, input logic [7:0] rdata, input logic fl,
                      input logic exp_wr, input logic [7:0] exp_d);
        wr_t e;
        in_valid = 1; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
        in_alu_result = alu; in_pc = pc; in_imm = imm;
        mem_rvalid = rv; mem_rdata = rdata; flush = fl;
        if (exp_wr) begin
            e.a = rd; e.d = exp_d;
            sb.push_back(e);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        @(negedge clk);
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we",       {31'd0, write_enable}, 32'd0);
        chk("rst_waddr",    {29'd0, write_address}, 32'd0);
        chk("rst_wdata",    {24'd0, write_data}, 32'd0);
        chk("rst_pending",  {31'd0, fwd_pending}, 32'd0);
        chk("rst_fwd_rd",   {29'd0, fwd_rd}, 32'd0);
        chk("rst_count",    {16'd0, retired_count}, 32'd0);
        rst = 0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // 1: ALU op, one-cycle pulse, count 1, address held afterwards.
        op(1, 3'd3, 2'b00, 8'h5A, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h5A);
        chk("t1_count", {16'd0, retired_count}, 32'd1);
        step();
        chk("t1_pulse_end", {31'd0, write_enable}, 32'd0);
        chk("t1_addr_hold", {29'd0, write_address}, 32'd3);
        chk("t1_data_hold", {24'd0, write_data}, 32'h5A);

        // 2: load rd=5, data 3 cycles after accept; in_valid ignored meanwhile.
        op(1, 3'd5, 2'b01, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t2_pending",  {31'd0, fwd_pending}, 32'd1);
            chk("t2_fwd_rd",   {29'd0, fwd_rd}, 32'd5);
            chk("t2_no_we",    {31'd0, write_enable}, 32'd0);
            in_valid = 1; in_reg_write = 1; in_rd = 3'd6; in_alu_result = 8'h11;
            step();
        end
        sb.push_back('{a: 3'd5, d: 8'hC3});
        in_valid = 1; in_rd = 3'd6; mem_rvalid = 1; mem_rdata = 8'hC3;
        step();
        idle_inputs();
        chk("t2_pending_clr", {31'd0, fwd_pending}, 32'd0);
        chk("t2_count", {16'd0, retired_count}, 32'd2);
        chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("t2_single_pulse", {31'd0, write_enable}, 32'd0);

        // 3: rd=0 retires without writing.
        op(1, 3'd0, 2'b00, 8'h77, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        chk("t3_no_we", {31'd0, write_enable}, 32'd0);
        chk("t3_count", {16'd0, retired_count}, 32'd3);

        // 4: link wraps, immediate, load hit in same cycle, stray rvalid.
        op(1, 3'd1, 2'b10, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 0, 1, 8'h00);
        op(1, 3'd2, 2'b11, 8'h00, 8'h00, 8'h80, 0, 8'h00, 0, 1, 8'h80);
        op(1, 3'd7, 2'b01, 8'h00, 8'h00, 8'h00, 1, 8'h3C, 0, 1, 8'h3C);
        chk("t4_count", {16'd0, retired_count}, 32'd6);
        mem_rvalid = 1; mem_rdata = 8'hEE;
        step();
        idle_inputs();
        chk("t4_stray_rvalid_we", {31'd0, write_enable}, 32'd0);
        chk("t4_stray_rvalid_cnt", {16'd0, retired_count}, 32'd6);

        // 5: flush beats rvalid in LOAD_WAIT; flush in IDLE; back-to-back ALU.
        op(1, 3'd4, 2'b01, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        flush = 1; mem_rvalid = 1; mem_rdata = 8'hAA;
        step();
        idle_inputs();
        chk("t5_flush_we",      {31'd0, write_enable}, 32'd0);
        chk("t5_flush_pending", {31'd0, fwd_pending}, 32'd0);
        chk("t5_flush_ready",   {31'd0, in_ready}, 32'd1);
        chk("t5_flush_count",   {16'd0, retired_count}, 32'd6);
        op(1, 3'd3, 2'b00, 8'h99, 8'h00, 8'h00, 0, 8'h00, 1, 0, 8'h00);
        chk("t5_idle_flush_we",  {31'd0, write_enable}, 32'd0);
        chk("t5_idle_flush_cnt", {16'd0, retired_count}, 32'd6);
        for (int i = 1; i <= 4; i++) begin
            logic [7:0] d;
            d = 8'h10 + 8'(i);
            in_valid = 1; in_reg_write = 1; in_rd = 3'(i); in_wb_sel = 2'b00;
            in_alu_result = d;
            sb.push_back('{a: 3'(i), d: d});
            step();
            chk("t5_b2b_we", {31'd0, write_enable}, 32'd1);
        end
        idle_inputs();
        step();
        chk("t5_b2b_end", {31'd0, write_enable}, 32'd0);
        chk("t5_count", {16'd0, retired_count}, 32'd10);

        // 6: reset mid LOAD_WAIT, then counter wrap.
        op(1, 3'd6, 2'b01, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        chk("t6_pending", {31'd0, fwd_pending}, 32'd1);
        rst = 1;
        step();
        chk("t6_rst_we",      {31'd0, write_enable}, 32'd0);
        chk("t6_rst_waddr",   {29'd0, write_address}, 32'd0);
        chk("t6_rst_wdata",   {24'd0, write_data}, 32'd0);
        chk("t6_rst_pending", {31'd0, fwd_pending}, 32'd0);
        chk("t6_rst_fwd_rd",  {29'd0, fwd_rd}, 32'd0);
        chk("t6_rst_count",   {16'd0, retired_count}, 32'd0);
        rst = 0;
        #1;
        chk("t6_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1; in_reg_write = 0; in_rd = 3'd1; in_wb_sel = 2'b00;
        for (int i = 0; i < 65535; i++) step();
        idle_inputs();
        chk("t6_count_max", {16'd0, retired_count}, 32'hFFFF);
        op(1, 3'd2, 2'b00, 8'h42, 8'h00, 8'h00, 0, 8'h00, 0, 1, 8'h42);
        chk("t6_count_wrap", {16'd0, retired_count}, 32'd0);

        step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
